// File: rtl/conc_trace_recorder.sv
// Run-length trace recorder: packs observation runs into {obs, run}
// records and queues them in a show-ahead FIFO with a valid/ready drain port.
module conc_trace_recorder #(
    parameter int OBS_W  = 6,
    parameter int CNT_W  = 6,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [OBS_W-1:0]       obs_in,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [OBS_W+CNT_W-1:0] rd_data,
    output logic [ADDR_W:0]        level,
    output logic                   overflow,
    output logic [7:0]             drop_cnt
);

    localparam int REC_W = OBS_W + CNT_W;
    localparam logic [CNT_W-1:0] RUN_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] RUN_ONE = CNT_W'(1);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state_q, state_d;
    logic [OBS_W-1:0] cur_q, cur_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic emit;
    logic [REC_W-1:0] emit_rec;

    logic [REC_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0] level_q;
    logic overflow_q;
    logic [7:0] drop_q;
    logic pop, push_ok;

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        run_d    = run_q;
        emit     = 1'b0;
        emit_rec = {cur_q, run_q};
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    cur_d   = obs_in;
                    run_d   = RUN_ONE;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    emit    = 1'b1;
                    state_d = IDLE;
                end else if (obs_in != cur_q) begin
                    emit  = 1'b1;
                    cur_d = obs_in;
                    run_d = RUN_ONE;
                end else if (run_q == RUN_MAX) begin
                    // Saturated run: this sample opens a new record
                    emit  = 1'b1;
                    run_d = RUN_ONE;
                end else begin
                    run_d = run_q + RUN_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop     = (level_q != '0) && rd_ready;
    assign push_ok = emit && ((level_q != DEPTH_L) || pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cur_q      <= '0;
            run_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            run_q   <= run_d;
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            if (push_ok && !pop)
                level_q <= level_q + (ADDR_W+1)'(1);
            else if (pop && !push_ok)
                level_q <= level_q - (ADDR_W+1)'(1);
            if (emit && !push_ok) begin
                overflow_q <= 1'b1;
                if (drop_q != 8'hFF)
                    drop_q <= drop_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok && !reset)
            mem_q[wr_ptr_q] <= emit_rec;
    end

    assign rd_valid = (level_q != '0);
    assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_q;

endmodule

// File: doc/conc_trace_recorder.md
Name: conc_trace_recorder

Overview:
- Capture-side counterpart of the opcode stimulus player in the concolic test harness.
- Samples the DUT observation vector (e.g. {cts, ctr, v_out}) each enabled clock and run-length encodes it into 12-bit trace words, matching the stimulus opcode width.
- Buffers trace words in an internal show-ahead FIFO.
- A valid/ready read port lets the bench or a dump engine drain the trace for comparison against the expected response.

Parameters:
OBS_W, 6, width of observation vector
CNT_W, 6, width of run-length field; maximum run = 2^CNT_W-1
DEPTH, 16, FIFO depth in records (power of two)
ADDR_W, 4, log2(DEPTH)

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
enable  input  1  sample obs_in on this edge when high
obs_in  input  OBS_W  observation vector from DUT
rd_valid  output  1  FIFO non-empty; rd_data holds oldest record
rd_ready  input  1  consumer accepts rd_data when rd_valid=1
rd_data  output  OBS_W+CNT_W  record {obs[OBS_W-1:0], run[CNT_W-1:0]}
level  output  ADDR_W+1  records currently stored, 0..DEPTH
overflow  output  1  sticky: a record was dropped because the FIFO was full
drop_cnt  output  8  dropped-record count, saturates at 255

Behaviour:
- Reset (synchronous, edge with reset=1):
  - FSM to IDLE; cur and run cleared.
  - FIFO pointers and level cleared; rd_valid=0; rd_data=0.
  - overflow=0; drop_cnt=0.
  - Applies mid-operation: the pending run is discarded, no record is emitted, and FIFO contents are lost.
- FSM states: IDLE, RUN.
- IDLE:
  - enable=1 → cur<=obs_in, run<=1, go RUN.
  - enable=0 → stay IDLE, nothing emitted.
- RUN, enable=1:
  - obs_in==cur and run<2^CNT_W-1 → run<=run+1.
  - obs_in!=cur → emit {cur,run}; cur<=obs_in; run<=1.
  - obs_in==cur and run==2^CNT_W-1 → emit {cur,max}; run<=1 (this sample starts a new record with the same value).
- RUN, enable=0: emit {cur,run}, go IDLE. The enable-low cycle is not sampled.
- Emit means a push request to the FIFO on that edge.
- Push acceptance:
  - Accepted when level<DEPTH, or when level==DEPTH and a pop occurs on the same edge.
  - Otherwise the record is dropped: overflow<=1 and drop_cnt<=drop_cnt+1 (saturating).
- Pop: occurs when rd_valid && rd_ready.
- FIFO is show-ahead:
  - rd_data = head record whenever level>0; rd_data=0 when empty.
  - rd_valid = (level!=0).
- Level arithmetic:
  - Simultaneous push and pop: level unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
  - level is registered and reflects the post-edge count.
- Latency: a record emitted on edge N appears on rd_data, with rd_valid=1 if the FIFO was empty, after edge N. It is poppable from edge N+1.
- Pop on an empty FIFO (rd_ready with rd_valid=0): no effect.
- overflow and drop_cnt clear only on reset.
- Only the pending run register is internal; there is no combinational path from obs_in to any output.

Test Plan:
1. Reset; enable=1 for 10 cycles with obs_in=6'h15; then enable=0 → exactly one record 12'h54A ({6'h15,6'd10}); level=1; overflow=0.
2. Enabled samples 6'h01, 6'h02, 6'h01, then enable=0 → three records in order: 12'h041, 12'h081, 12'h041.
3. obs_in=6'h3F held for 70 enabled cycles, then disable → records 12'hFFF ({3F,63}) then 12'hFC7 ({3F,7}).
4. rd_ready=0; produce 20 single-cycle records with alternating values → level=16, overflow=1, drop_cnt=4. Draining yields the first 16 records in order, then rd_valid=0 and level=0.
5. FIFO full with rd_ready=1 when a new record is emitted → push accepted, level stays 16, overflow stays 0, head advances.
6. Reset asserted after 5 enabled cycles of a constant run with 2 records already queued → next cycle level=0, rd_valid=0, rd_data=0. The pending run is never emitted; FSM is IDLE and restarts cleanly on the next enable.
